// File: rtl/dp_ram_lane_if.sv
// Bus interface for dp_ram_lane: two access ports, zeroize control and
// collision status. The slave modport is used by the RAM and the master
// modport by whatever drives it.
// Optional macro LANE_PARITY_EN adds parity-error injection inputs and
// parity-error outputs.
interface dp_ram_lane_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int NUM_LANES  = 4,
  parameter int LANE_WIDTH = 16
);
  localparam int DATA_WIDTH = NUM_LANES * LANE_WIDTH;

  logic                  clr_req;
  logic                  clr_busy;
  logic                  clr_done;

  logic                  en_a;
  logic [NUM_LANES-1:0]  we_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] din_a;
  logic [DATA_WIDTH-1:0] dout_a;
  logic                  dvalid_a;

  logic                  en_b;
  logic [NUM_LANES-1:0]  we_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] din_b;
  logic [DATA_WIDTH-1:0] dout_b;
  logic                  dvalid_b;

  logic                  collision;

`ifdef LANE_PARITY_EN
  logic                  perr_inj_a;
  logic                  perr_inj_b;
  logic                  perr_a;
  logic                  perr_b;
`endif

  modport slave (
`ifdef LANE_PARITY_EN
    input  perr_inj_a, perr_inj_b,
    output perr_a, perr_b,
`endif
    input  clr_req,
    output clr_busy, clr_done,
    input  en_a, we_a, addr_a, din_a,
    output dout_a, dvalid_a,
    input  en_b, we_b, addr_b, din_b,
    output dout_b, dvalid_b,
    output collision
  );

  modport master (
`ifdef LANE_PARITY_EN
    output perr_inj_a, perr_inj_b,
    input  perr_a, perr_b,
`endif
    output clr_req,
    input  clr_busy, clr_done,
    output en_a, we_a, addr_a, din_a,
    input  dout_a, dvalid_a,
    output en_b, we_b, addr_b, din_b,
    input  dout_b, dvalid_b,
    input  collision
  );
endinterface

// File: rtl/dp_ram_lane.sv
// dp_ram_lane: true dual-port RAM organised as NUM_LANES write lanes of
// LANE_WIDTH bits, read-first on both ports, optional output register,
// same-address collision flag and a zeroize sweep for secret data.
// Optional macro LANE_PARITY_EN: one even-parity bit per lane, error
// injection on write and a per-port parity-error flag on read.
//
// Zeroize FSM
//   state    | meaning
//   ST_IDLE  | normal operation, clr_req starts a sweep
//   ST_CLEAR | writes zero to address cnt each cycle, user accesses ignored
//   ST_DONE  | one-cycle clr_done pulse, user accesses accepted again
module dp_ram_lane #(
  parameter int ADDR_WIDTH = 7,
  parameter int NUM_LANES  = 4,
  parameter int LANE_WIDTH = 16,
  parameter int OUT_REG    = 0,
  parameter     INIT_FILE  = ""
) (
  input  logic         clk,
  input  logic         rst_n,
  dp_ram_lane_if.slave bus
);
  localparam int DATA_WIDTH = NUM_LANES * LANE_WIDTH;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DONE} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic                  clr_busy_q;
  logic                  clr_done_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  sweep;
  logic                  acc_a;
  logic                  acc_b;
  logic [DATA_WIDTH-1:0] rd_a_d;
  logic [DATA_WIDTH-1:0] rd_b_d;
  logic                  collision_d;

  logic                  out_vld_a;
  logic                  out_vld_b;
  logic [DATA_WIDTH-1:0] out_dat_a;
  logic [DATA_WIDTH-1:0] out_dat_b;

  logic [DATA_WIDTH-1:0] dout_a_q;
  logic [DATA_WIDTH-1:0] dout_b_q;
  logic                  dvalid_a_q;
  logic                  dvalid_b_q;
  logic                  collision_q;

  assign sweep  = (state_q == ST_CLEAR);
  assign acc_a  = bus.en_a && !sweep;
  assign acc_b  = bus.en_b && !sweep;
  assign rd_a_d = mem_q[bus.addr_a];
  assign rd_b_d = mem_q[bus.addr_b];

  assign collision_d = acc_a && acc_b && (bus.addr_a == bus.addr_b) &&
                       ((|bus.we_a) || (|bus.we_b));

  // Zeroize sequencer: sweeps every address once, then pulses done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.clr_req) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            clr_busy_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          cnt_q <= cnt_q + (ADDR_WIDTH + 1)'(1);
          if (cnt_q[ADDR_WIDTH-1:0] == {ADDR_WIDTH{1'b1}}) begin
            state_q    <= ST_DONE;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
        default: begin
          state_q    <= ST_IDLE;
          cnt_q      <= '0;
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Array writes: sweep zeroes one word, otherwise per-lane user writes.
  // Port A is applied last so it owns lanes written by both ports.
  always_ff @(posedge clk) begin
    if (sweep) begin
      mem_q[cnt_q[ADDR_WIDTH-1:0]] <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (acc_b && bus.we_b[i])
          mem_q[bus.addr_b][i*LANE_WIDTH +: LANE_WIDTH] <= bus.din_b[i*LANE_WIDTH +: LANE_WIDTH];
        if (acc_a && bus.we_a[i])
          mem_q[bus.addr_a][i*LANE_WIDTH +: LANE_WIDTH] <= bus.din_a[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

`ifdef LANE_PARITY_EN
  logic [NUM_LANES-1:0] par_q [DEPTH];
  logic [NUM_LANES-1:0] rd_par_a;
  logic [NUM_LANES-1:0] rd_par_b;
  logic                 rd_perr_a_d;
  logic                 rd_perr_b_d;
  logic                 out_perr_a;
  logic                 out_perr_b;
  logic                 perr_a_q;
  logic                 perr_b_q;

  assign rd_par_a = par_q[bus.addr_a];
  assign rd_par_b = par_q[bus.addr_b];

  // Parity bits follow the same lane ownership as the data array
  always_ff @(posedge clk) begin
    if (sweep) begin
      par_q[cnt_q[ADDR_WIDTH-1:0]] <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (acc_b && bus.we_b[i])
          par_q[bus.addr_b][i] <= (^bus.din_b[i*LANE_WIDTH +: LANE_WIDTH]) ^ bus.perr_inj_b;
        if (acc_a && bus.we_a[i])
          par_q[bus.addr_a][i] <= (^bus.din_a[i*LANE_WIDTH +: LANE_WIDTH]) ^ bus.perr_inj_a;
      end
    end
  end

  // Any lane whose data and parity bit do not XOR to zero flags an error
  always_comb begin
    rd_perr_a_d = 1'b0;
    rd_perr_b_d = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      rd_perr_a_d = rd_perr_a_d | ((^rd_a_d[i*LANE_WIDTH +: LANE_WIDTH]) ^ rd_par_a[i]);
      rd_perr_b_d = rd_perr_b_d | ((^rd_b_d[i*LANE_WIDTH +: LANE_WIDTH]) ^ rd_par_b[i]);
    end
  end
`endif

  if (OUT_REG != 0) begin : g_oreg
    logic                  vld_a_q;
    logic                  vld_b_q;
    logic [DATA_WIDTH-1:0] dat_a_q;
    logic [DATA_WIDTH-1:0] dat_b_q;
`ifdef LANE_PARITY_EN
    logic                  perr_s1_a_q;
    logic                  perr_s1_b_q;
`endif

    // Extra stage: holds the read-first word for one more cycle
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_a_q <= 1'b0;
        vld_b_q <= 1'b0;
        dat_a_q <= '0;
        dat_b_q <= '0;
`ifdef LANE_PARITY_EN
        perr_s1_a_q <= 1'b0;
        perr_s1_b_q <= 1'b0;
`endif
      end else begin
        vld_a_q <= acc_a;
        vld_b_q <= acc_b;
        if (acc_a) dat_a_q <= rd_a_d;
        if (acc_b) dat_b_q <= rd_b_d;
`ifdef LANE_PARITY_EN
        perr_s1_a_q <= acc_a & rd_perr_a_d;
        perr_s1_b_q <= acc_b & rd_perr_b_d;
`endif
      end
    end

    assign out_vld_a = vld_a_q;
    assign out_vld_b = vld_b_q;
    assign out_dat_a = dat_a_q;
    assign out_dat_b = dat_b_q;
`ifdef LANE_PARITY_EN
    assign out_perr_a = perr_s1_a_q;
    assign out_perr_b = perr_s1_b_q;
`endif
  end else begin : g_noreg
    assign out_vld_a = acc_a;
    assign out_vld_b = acc_b;
    assign out_dat_a = rd_a_d;
    assign out_dat_b = rd_b_d;
`ifdef LANE_PARITY_EN
    assign out_perr_a = rd_perr_a_d;
    assign out_perr_b = rd_perr_b_d;
`endif
  end

  // Output registers: data holds between valid cycles, collision is one cycle late
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_a_q    <= '0;
      dout_b_q    <= '0;
      dvalid_a_q  <= 1'b0;
      dvalid_b_q  <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      dvalid_a_q  <= out_vld_a;
      dvalid_b_q  <= out_vld_b;
      collision_q <= collision_d;
      if (out_vld_a) dout_a_q <= out_dat_a;
      if (out_vld_b) dout_b_q <= out_dat_b;
    end
  end

`ifdef LANE_PARITY_EN
  // Parity flags are only meaningful alongside dvalid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_a_q <= 1'b0;
      perr_b_q <= 1'b0;
    end else begin
      perr_a_q <= out_vld_a & out_perr_a;
      perr_b_q <= out_vld_b & out_perr_b;
    end
  end

  assign bus.perr_a = perr_a_q;
  assign bus.perr_b = perr_b_q;
`endif

  assign bus.dout_a    = dout_a_q;
  assign bus.dout_b    = dout_b_q;
  assign bus.dvalid_a  = dvalid_a_q;
  assign bus.dvalid_b  = dvalid_b_q;
  assign bus.collision = collision_q;
  assign bus.clr_busy  = clr_busy_q;
  assign bus.clr_done  = clr_done_q;
endmodule
